// File: rtl/program_counter.sv
// program_counter: IF-stage PC register for the 16-bit pipelined MIPS core.
// Loads PC_in on every non-reset rising edge. It also provides the sequential
// successor address (PC_plus) and the previously held PC (PC_prev) for EPC use.
// Optional feature: define PC_ALIGN_CHECK_EN to enable the registered
// fetch-target misalignment flag (align_err). Without it, align_err is tied to 0.
module program_counter #(
  parameter int unsigned          WIDTH       = 16,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0,
  parameter int unsigned          INCR        = 1,
  parameter int unsigned          ALIGN_BITS  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] PC_in,
  output logic [WIDTH-1:0] PC_out,
  output logic [WIDTH-1:0] PC_plus,
  output logic [WIDTH-1:0] PC_prev,
  output logic             align_err
);

  localparam logic [WIDTH-1:0] INCR_W = WIDTH'(INCR);

  // Declaration initializers give a defined power-up value in simulation only;
  // silicon relies on rst being asserted before use.
  logic [WIDTH-1:0] pc_out_q  = RESET_VALUE;
  logic [WIDTH-1:0] pc_prev_q = RESET_VALUE;
  logic [WIDTH-1:0] pc_out_d;
  logic [WIDTH-1:0] pc_prev_d;

  // Next-state for the PC pair: reset wins, otherwise shift PC_out into PC_prev and load PC_in verbatim
  always_comb begin
    pc_out_d  = pc_out_q;
    pc_prev_d = pc_prev_q;
    if (rst) begin
      pc_out_d  = RESET_VALUE;
      pc_prev_d = RESET_VALUE;
    end else begin
      pc_out_d  = PC_in;
      pc_prev_d = pc_out_q;
    end
  end

  // PC register pair, loaded unconditionally every edge (stalls recirculate PC_out upstream)
  always_ff @(posedge clk) begin
    pc_out_q  <= pc_out_d;
    pc_prev_q <= pc_prev_d;
  end

  assign PC_out  = pc_out_q;
  assign PC_prev = pc_prev_q;
  assign PC_plus = pc_out_q + INCR_W;

`ifdef PC_ALIGN_CHECK_EN
  logic align_err_q = 1'b0;
  logic align_err_d;
  logic align_bad;

  // Low ALIGN_BITS of the incoming target must be zero; with zero bits nothing can be misaligned
  if (ALIGN_BITS > 0) begin : g_align_chk
    assign align_bad = |PC_in[ALIGN_BITS-1:0];
  end else begin : g_align_none
    assign align_bad = 1'b0;
  end

  // Flag follows the value being loaded; reset clears it
  always_comb begin
    align_err_d = 1'b0;
    if (!rst) begin
      align_err_d = align_bad;
    end
  end

  // Flag register, aligned in time with PC_out
  always_ff @(posedge clk) begin
    align_err_q <= align_err_d;
  end

  assign align_err = align_err_q;
`else
  assign align_err = 1'b0;
`endif

endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter: directed scoreboard bench for program_counter.
// Define PC_ALIGN_CHECK_EN for both bench and RTL to exercise the alignment flag.
module tb_program_counter;

  localparam int unsigned   W      = 16;
  localparam logic [W-1:0]  RV     = 16'h0000;
  localparam int unsigned   ALIGNB = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] PC_in = '0;
  logic [W-1:0] PC_out;
  logic [W-1:0] PC_plus;
  logic [W-1:0] PC_prev;
  logic         align_err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0] pc_out;
    logic [W-1:0] pc_prev;
    logic [W-1:0] pc_plus;
    logic         align;
  } exp_t;

  exp_t sb[$];

  logic [W-1:0] m_out  = RV;
  logic [W-1:0] m_prev = RV;

  program_counter #(
    .WIDTH(W),
    .RESET_VALUE(RV),
    .INCR(1),
    .ALIGN_BITS(ALIGNB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .PC_in(PC_in),
    .PC_out(PC_out),
    .PC_plus(PC_plus),
    .PC_prev(PC_prev),
    .align_err(align_err)
  );

  // Free-running clock, first rising edge at 5
  always #5 clk = ~clk;

  // Reference misalignment of a target under the build's configuration
  function automatic logic expAlign(input logic [W-1:0] v);
    logic [W-1:0] mask;
    mask = (W'(1) << ALIGNB) - W'(1);
`ifdef PC_ALIGN_CHECK_EN
    return ((v & mask) != '0);
`else
    return 1'b0 & (mask == '0);
`endif
  endfunction

  task automatic cmp(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one edge's inputs, record the expected result, then advance past the edge
  task automatic applyStimulus(input logic r, input logic [W-1:0] pin);
    exp_t e;
    rst   = r;
    PC_in = pin;
    if (r) begin
      m_out   = RV;
      m_prev  = RV;
      e.align = 1'b0;
    end else begin
      m_prev  = m_out;
      m_out   = pin;
      e.align = expAlign(pin);
    end
    e.pc_out  = m_out;
    e.pc_prev = m_prev;
    e.pc_plus = m_out + W'(1);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Pop the oldest expectation and compare all outputs against it
  task automatic checkOutput(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL %s scoreboard empty observed=0 expected=1", tag);
      return;
    end
    e = sb.pop_front();
    cmp({tag, ".out"},   PC_out,  e.pc_out);
    cmp({tag, ".prev"},  PC_prev, e.pc_prev);
    cmp({tag, ".plus"},  PC_plus, e.pc_plus);
    cmp({tag, ".align"}, W'(align_err), W'(e.align));
  endtask

  initial begin
    #1;
    cmp("pwrup.out",   PC_out,  RV);
    cmp("pwrup.prev",  PC_prev, RV);
    cmp("pwrup.plus",  PC_plus, RV + W'(1));
    cmp("pwrup.align", W'(align_err), '0);

    applyStimulus(1'b0, 16'h0000); checkOutput("first");
    applyStimulus(1'b0, 16'h1111); checkOutput("load1111");
    applyStimulus(1'b1, 16'h1234); checkOutput("rst_ovr");
    applyStimulus(1'b0, 16'h0003); checkOutput("mis0003");
    applyStimulus(1'b0, 16'h0004); checkOutput("ali0004");

    applyStimulus(1'b1, 16'hAAAA); checkOutput("rsthold1");
    applyStimulus(1'b1, 16'h5555); checkOutput("rsthold2");
    applyStimulus(1'b1, 16'hAAAA); checkOutput("rsthold3");
    applyStimulus(1'b0, 16'h5555); checkOutput("release");

    applyStimulus(1'b0, 16'hFFFF); checkOutput("wrap");
    applyStimulus(1'b0, 16'h0001); checkOutput("afterwrap");

    PC_in = 16'hBEEF;
    #2;
    cmp("between.out",  PC_out,  m_out);
    cmp("between.prev", PC_prev, m_prev);

    applyStimulus(1'b0, 16'h0007); checkOutput("mis0007");
    applyStimulus(1'b1, 16'h0003); checkOutput("rst_clr_align");
    applyStimulus(1'b0, 16'h8000); checkOutput("load8000");

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("[TB] FAIL sb_drain observed=%0d expected=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
